// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory access unit.
// One request in flight; loads, sub-word stores (read-modify-write) and SW
// are sequenced by a small FSM against a single-port combinational DataMemory.
// Optional build macro LSU_RANGE_CHECK_EN: addresses >= MEM_BYTES fault.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  if (MEM_BYTES < 4 || (MEM_BYTES & (MEM_BYTES - 1)) != 0) begin : g_bad_mem_bytes
    $error("MEM_BYTES must be a power of two and at least 4");
  end

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic        req_fault;

  // Select the addressed lane and sign/zero-extend per the load width code.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return w;
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  // Overlay store data onto the previously read word; SW replaces it outright.
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] wd,
                                              input logic [1:0] a, input logic [2:0] f3);
    logic [31:0] m;
    m = w;
    case (f3[1:0])
      2'b00:   m[{a, 3'b000} +: 8]    = wd[7:0];
      2'b01:   m[{a[1], 4'b0000} +: 16] = wd[15:0];
      default: m = wd;
    endcase
    return m;
  endfunction

  // Reject illegal width codes, misaligned halfwords/words and (optionally) out-of-range addresses.
  always_comb begin
    req_fault = 1'b0;
    if (req_we) req_fault = (req_funct3 > 3'b010);
    else        req_fault = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    if (req_funct3[1:0] == 2'b01 && req_addr[0])          req_fault = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_fault = 1'b1;
`ifdef LSU_RANGE_CHECK_EN
    if (req_addr >= 32'(MEM_BYTES)) req_fault = 1'b1;
`endif
  end

  // Next-state and datapath: latch on accept, capture read word, build response.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 32'd0;
          fault_d = req_fault;
          if (req_fault)                          state_d = RESP;
          else if (req_we && req_funct3 == 3'b010) state_d = WRITE;
          else                                    state_d = READ;
        end
      end
      READ: begin
        word_d = mem_rdata;
        if (we_q) state_d = WRITE;
        else begin
          rdata_d = load_ext(mem_rdata, addr_q[1:0], f3_q);
          state_d = RESP;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched request/data registers, synchronously cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // Strobes and handshakes decode from state; reset kills them immediately so
  // a write in flight never lands.
  always_comb begin
    req_ready  = (state_q == IDLE) && !reset;
    mem_read   = (state_q == READ) && !reset;
    mem_write  = (state_q == WRITE) && !reset;
    mem_addr   = (state_q == READ || state_q == WRITE) ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_wdata  = (state_q == WRITE) ? store_merge(word_q, wdata_q, addr_q[1:0], f3_q) : 32'd0;
    resp_valid = (state_q == RESP) && !reset;
    resp_fault = resp_valid && fault_q;
    resp_rdata = resp_valid ? rdata_q : 32'd0;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 4096, data-memory size in bytes (power of two, at least 4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  CPU access request.
REQ-005 SHALL have port req_ready  output  1  unit idle, request accepted this cycle.
REQ-006 SHALL have port req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port req_funct3  input  3  RV32I width code: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, low bits used for sub-word stores.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  extended load result; 0 for stores and faults.
REQ-012 SHALL have port resp_fault  output  1  access rejected, valid with resp_valid.
REQ-013 SHALL have ports mem_read, mem_write  output  1 each  DataMemory strobes.
REQ-014 SHALL have ports mem_addr, mem_wdata  output  32 each  word-aligned address and write word.
REQ-015 SHALL have port mem_rdata  input  32  combinational DataMemory read word.

Function
REQ-016 SHALL accept a request when req_valid && req_ready, latching we, funct3, addr, wdata; req_ready = (state==IDLE) && !reset.
REQ-017 SHALL use FSM states IDLE, READ, WRITE, RESP.
REQ-018 Transitions SHALL be: IDLE->RESP on fault; load IDLE->READ->RESP; SW IDLE->WRITE->RESP; SB/SH IDLE->READ->WRITE->RESP; RESP->IDLE always.
REQ-019 Latency from acceptance edge to resp_valid high SHALL be 2 cycles for load, 2 for SW, 3 for SB/SH, 1 for fault.
REQ-020 SHALL fault on: illegal funct3 (load 011/110/111; store other than 000-010), halfword with addr[0]=1, word with addr[1:0]!=0; a faulted request SHALL NOT assert mem_read or mem_write.
REQ-021 mem_addr SHALL be {addr[31:2],2'b00} of the latched request in READ and WRITE, 0 otherwise.
REQ-022 mem_read SHALL be 1 only in READ; mem_write SHALL be 1 only in WRITE; never both.
REQ-023 In READ, SHALL capture mem_rdata into a word register at the clock edge.
REQ-024 Loads SHALL select lane addr[1:0] (byte) or addr[1] (half) and sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes the word.
REQ-025 SB/SH SHALL merge req_wdata[7:0]/[15:0] into the captured word at the addressed lane, other bytes unchanged; SW writes req_wdata unmodified.
REQ-026 resp_valid SHALL be high exactly one cycle (RESP); resp_rdata/resp_fault valid only then, 0 otherwise.
REQ-027 req_valid SHALL be ignored outside IDLE; no queuing.

Reset
REQ-028 reset high SHALL set state IDLE and clear all latched request and data registers at the next edge.
REQ-029 While reset is high, mem_read, mem_write, resp_valid, resp_fault, req_ready SHALL be forced 0 combinationally, so reset asserted in WRITE suppresses that write.
REQ-030 An operation interrupted by reset SHALL be abandoned with no response.

Configuration
REQ-031 With macro LSU_RANGE_CHECK_EN defined, any access with addr >= MEM_BYTES SHALL fault (REQ-020 path, no memory strobe).
REQ-032 Without LSU_RANGE_CHECK_EN, out-of-range addresses SHALL be passed to memory unchanged.

Verification
REQ-033 SW 0xABCD1234 at 0x004, then LW 0x004 -> mem_write one cycle with mem_addr 0x004; LW resp_rdata 0xABCD1234, fault 0, latency 2.
REQ-034 Word 0x11223344 at 0x008; SB 0xAA at 0x009, then LW 0x008 -> 0x1122AA44; SB latency 3; LB 0x009 -> 0xFFFFFFAA; LBU 0x009 -> 0x000000AA.
REQ-035 Word 0x8001FFFF at 0x0FFC; LH 0x0FFE -> 0xFFFF8001; LHU 0x0FFC -> 0x0000FFFF.
REQ-036 LW 0x002, SH 0x003, funct3 011 load -> resp_fault 1 after 1 cycle, mem_read/mem_write never high, memory unchanged.
REQ-037 LW 0x1000 -> with LSU_RANGE_CHECK_EN resp_fault 1, no strobe; without, mem_read high with mem_addr 0x1000.
REQ-038 Assert reset in WRITE of SB -> mem_write 0 that cycle, no resp_valid, req_ready 1 the cycle after reset drops, target word unchanged.
